// File: rtl/in_fm_pkg.sv
// Shared definitions for the input-feature-map tile path: tile geometry
// helpers and the store-side FSM state encoding.
package in_fm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Input tile rows needed to produce out_rows output rows.
  function automatic int unsigned in_tile_rows(input int unsigned out_rows,
                                               input int unsigned ksize,
                                               input int unsigned stride);
    return (out_rows - 1) * stride + ksize;
  endfunction

  // Input tile cols needed to produce out_cols output cols.
  function automatic int unsigned in_tile_cols(input int unsigned out_cols,
                                               input int unsigned ksize,
                                               input int unsigned stride);
    return (out_cols - 1) * stride + ksize;
  endfunction

  // Total words in one input tile across all channels.
  function automatic int unsigned in_tile_words(input int unsigned n_ch,
                                                input int unsigned n_rows,
                                                input int unsigned n_cols);
    return n_ch * n_rows * n_cols;
  endfunction

endpackage

// File: rtl/in_fm_tile_cnt.sv
// Nested ch/row/col walker over one input tile, col fastest. Exposes the
// per-level wrap flags and a flag marking the final word of the tile.
module in_fm_tile_cnt
  import in_fm_pkg::*;
#(
  parameter int unsigned CW   = 16,
  parameter int unsigned NCH  = 16,
  parameter int unsigned NROW = 66,
  parameter int unsigned NCOL = 18
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] ch_o,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          col_wrap_o,
  output logic          row_wrap_o,
  output logic          last_o
);

  logic [CW-1:0] ch_q, ch_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  assign col_wrap_o = (col_q == CW'(NCOL - 1));
  assign row_wrap_o = (row_q == CW'(NROW - 1));
  assign last_o     = col_wrap_o && row_wrap_o && (ch_q == CW'(NCH - 1));
  assign ch_o       = ch_q;
  assign row_o      = row_q;
  assign col_o      = col_q;

  // Next position: clear wins, otherwise advance col, carrying into row and ch.
  always_comb begin
    ch_d  = ch_q;
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      ch_d  = '0;
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_wrap_o) begin
        col_d = '0;
        if (row_wrap_o) begin
          row_d = '0;
          ch_d  = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ch_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      ch_q  <= ch_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/in_fm_fifo_to_buf.sv
// Drains one input-feature-map tile from the load FIFO and scatters each word
// into the Tn input buffer banks (bank = channel, address = row*TCI + col).
module in_fm_fifo_to_buf
  import in_fm_pkg::*;
#(
  parameter int unsigned AW = 12,
  parameter int unsigned CW = 16,
  parameter int unsigned DW = 32,
  parameter int unsigned Tn = 16,
  parameter int unsigned Tr = 64,
  parameter int unsigned Tc = 16,
  parameter int unsigned K  = 3,
  parameter int unsigned S  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          store_start,
  output logic          store_done,
  input  logic [DW-1:0] fifo_data,
  input  logic          fifo_empty,
  output logic          fifo_pop,
  output logic [Tn-1:0] in_fm_wena,
  output logic [AW-1:0] in_fm_waddr,
  output logic [DW-1:0] in_fm_wdata,
  output logic          busy
);

  localparam int unsigned TRI = in_tile_rows(Tr, K, S);
  localparam int unsigned TCI = in_tile_cols(Tc, K, S);

  if ((64'(TRI) * 64'(TCI) > (64'd1 << AW)) || (AW > CW)) begin : g_bad_geometry
    $error("in_fm_fifo_to_buf: input tile plane does not fit the bank address space");
  end

  state_e        state_q, state_d;
  logic          start_acc;
  logic [CW-1:0] cnt_ch, cnt_row, cnt_col;
  logic          cnt_col_wrap, cnt_row_wrap, cnt_last;
  logic [CW-1:0] tag_ch_q, tag_row_q, tag_col_q;
  logic          tag_v_q, tag_last_q;
  logic [Tn-1:0] wena_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic          wlast_q;
  logic          done_q, busy_q;
  logic [Tn-1:0] bank_oh;
  logic [CW-1:0] addr_full;
  logic          unused_wraps;

  // Start is only honoured from IDLE; any other start leaves counters alone.
  assign start_acc  = store_start && (state_q == ST_IDLE);
  assign fifo_pop   = (state_q == ST_LOAD) && !fifo_empty;

  assign store_done  = done_q;
  assign busy        = busy_q;
  assign in_fm_wena  = wena_q;
  assign in_fm_waddr = waddr_q;
  assign in_fm_wdata = wdata_q;

  // Wrap flags are consumed by the buffer reader, not here.
  assign unused_wraps = cnt_col_wrap ^ cnt_row_wrap;

  in_fm_tile_cnt #(
    .CW  (CW),
    .NCH (Tn),
    .NROW(TRI),
    .NCOL(TCI)
  ) u_cnt (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clr_i     (start_acc),
    .en_i      (fifo_pop),
    .ch_o      (cnt_ch),
    .row_o     (cnt_row),
    .col_o     (cnt_col),
    .col_wrap_o(cnt_col_wrap),
    .row_wrap_o(cnt_row_wrap),
    .last_o    (cnt_last)
  );

  // Bank select decode and in-bank address from the tag of the word in flight.
  always_comb begin
    bank_oh = '0;
    for (int unsigned i = 0; i < Tn; i++) begin
      bank_oh[i] = (tag_ch_q == CW'(i));
    end
  end

  assign addr_full = tag_row_q * CW'(TCI) + tag_col_q;

  if (CW > AW) begin : g_addr_hi
    logic [CW-AW-1:0] unused_addr_hi;
    assign unused_addr_hi = addr_full[CW-1:AW];
  end

  // Next-state: DRAIN ends once the last word's write is on the outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (store_start) state_d = ST_LOAD;
      ST_LOAD:  if (fifo_pop && cnt_last) state_d = ST_DRAIN;
      ST_DRAIN: if (wlast_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register plus registered done/busy derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == ST_DONE);
      busy_q  <= (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    end
  end

  // Tag register: position of the word popped this cycle, used when its data returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_ch_q   <= '0;
      tag_row_q  <= '0;
      tag_col_q  <= '0;
      tag_v_q    <= 1'b0;
      tag_last_q <= 1'b0;
    end else begin
      tag_v_q    <= fifo_pop;
      tag_last_q <= fifo_pop && cnt_last;
      if (fifo_pop) begin
        tag_ch_q  <= cnt_ch;
        tag_row_q <= cnt_row;
        tag_col_q <= cnt_col;
      end
    end
  end

  // Write stage: returning FIFO data plus its tag onto the bank write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wena_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wlast_q <= 1'b0;
    end else begin
      wena_q  <= tag_v_q ? bank_oh : '0;
      wlast_q <= tag_v_q && tag_last_q;
      if (tag_v_q) begin
        waddr_q <= addr_full[AW-1:0];
        wdata_q <= fifo_data;
      end
    end
  end

endmodule

// File: tb/tb_in_fm_fifo_to_buf.sv
`timescale 1ns/1ps
// Bench for in_fm_fifo_to_buf: small-tile instance exercised per scenario,
// plus a default-geometry instance for the full-size tile timing.
module tb_in_fm_fifo_to_buf;

  localparam int unsigned AW = 12;
  localparam int unsigned CW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TN = 2;
  localparam int unsigned TR = 2;
  localparam int unsigned TC = 2;
  localparam int unsigned K  = 3;
  localparam int unsigned S  = 1;
  localparam int TRI_M = (TR - 1) * S + K;
  localparam int TCI_M = (TC - 1) * S + K;
  localparam int BANK_WORDS = TRI_M * TCI_M;
  localparam int TW = TN * BANK_WORDS;

  localparam int DEF_TN  = 16;
  localparam int DEF_TRI = (64 - 1) * 1 + 3;
  localparam int DEF_TCI = (16 - 1) * 1 + 3;
  localparam int DEF_BW  = DEF_TRI * DEF_TCI;
  localparam int DEF_TW  = DEF_TN * DEF_BW;

  logic          clk;
  logic          rst;
  logic          store_start;
  logic          store_done;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [TN-1:0] in_fm_wena;
  logic [AW-1:0] in_fm_waddr;
  logic [DW-1:0] in_fm_wdata;
  logic          busy;

  logic          def_start, def_done, def_empty, def_pop, def_busy;
  logic [DW-1:0] def_data, def_wdata;
  logic [15:0]   def_wena;
  logic [AW-1:0] def_waddr;

  in_fm_fifo_to_buf #(
    .AW(AW), .CW(CW), .DW(DW), .Tn(TN), .Tr(TR), .Tc(TC), .K(K), .S(S)
  ) dut (
    .clk(clk), .rst(rst), .store_start(store_start), .store_done(store_done),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .in_fm_wena(in_fm_wena), .in_fm_waddr(in_fm_waddr), .in_fm_wdata(in_fm_wdata),
    .busy(busy)
  );

  in_fm_fifo_to_buf u_def (
    .clk(clk), .rst(rst), .store_start(def_start), .store_done(def_done),
    .fifo_data(def_data), .fifo_empty(def_empty), .fifo_pop(def_pop),
    .in_fm_wena(def_wena), .in_fm_waddr(def_waddr), .in_fm_wdata(def_wdata),
    .busy(def_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model for the small instance: words in mem[rd_ptr .. wr_ptr-1].
  logic [DW-1:0] mem [0:511];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  int  stall_lo = -1;
  int  stall_hi = -1;
  bit  rand_en = 1'b0;
  bit  rand_bit = 1'b0;

  always @(posedge clk) rand_bit <= 1'($urandom_range(0, 1));

  assign fifo_empty = (rd_ptr == wr_ptr) || ((cyc >= stall_lo) && (cyc <= stall_hi)) ||
                      (rand_en && rand_bit);

  always @(posedge clk) begin
    if (fifo_pop) begin
      fifo_data <= mem[9'(rd_ptr)];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Default-geometry source: never empty, word n carries value n.
  int def_ptr = 0;
  assign def_empty = 1'b0;
  always @(posedge clk) begin
    if (def_pop) begin
      def_data <= DW'(def_ptr);
      def_ptr  <= def_ptr + 1;
    end
  end

  typedef struct {
    logic [TN-1:0] wena;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            c;
  } wr_t;

  wr_t wr_q[$];
  int  pop_cyc[$];
  int  done_cyc[$];

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (|in_fm_wena) wr_q.push_back('{wena: in_fm_wena, addr: in_fm_waddr, data: in_fm_wdata, c: cyc});
      if (fifo_pop) pop_cyc.push_back(cyc);
      if (store_done) done_cyc.push_back(cyc);
    end
  end

  int          def_wr_cnt = 0;
  int          def_bad = 0;
  int          def_done_n = 0;
  int          def_done_cyc = -1;
  logic [15:0] def_last_wena = '0;
  logic [AW-1:0] def_last_addr = '0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (|def_wena) begin
        if (def_wena !== (16'(1) << (def_wr_cnt / DEF_BW)) ||
            def_waddr !== AW'(def_wr_cnt % DEF_BW) || def_wdata !== DW'(def_wr_cnt))
          def_bad <= def_bad + 1;
        def_last_wena <= def_wena;
        def_last_addr <= def_waddr;
        def_wr_cnt    <= def_wr_cnt + 1;
      end
      if (def_done && def_done_n == 0) def_done_cyc <= cyc;
      if (def_done) def_done_n <= def_done_n + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int n, input bit seq);
    for (int i = 0; i < n; i++) begin
      mem[9'(wr_ptr)] = seq ? DW'(wr_ptr) : $urandom;
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    pop_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic start_tile(output int c);
    store_start = 1'b1;
    c = cyc;
    step();
    store_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int limit, output bit to);
    to = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (done_cyc.size() >= n) begin
        to = 1'b0;
        break;
      end
      step();
    end
  endtask

  // Reference: word k of a tile goes to bank k/plane at address k%plane,
  // visible three cycles after start plus any stall cycles before its pop.
  function automatic int write_errors(input int q_off, input int base, input int c0,
                                      input int stall_k, input int stall_len, input bit chk_t);
    int e;
    e = 0;
    if (wr_q.size() < q_off + TW) return TW;
    for (int k = 0; k < TW; k++) begin
      logic [TN-1:0] exp_wena;
      int exp_c;
      exp_wena = TN'(1) << (k / BANK_WORDS);
      exp_c = c0 + 3 + k + ((k >= stall_k) ? stall_len : 0);
      if (wr_q[q_off + k].wena !== exp_wena || wr_q[q_off + k].addr !== AW'(k % BANK_WORDS) ||
          wr_q[q_off + k].data !== mem[9'(base + k)] || (chk_t && wr_q[q_off + k].c != exp_c))
        e++;
    end
    return e;
  endfunction

  function automatic int first_done();
    return (done_cyc.size() > 0) ? done_cyc[0] : -1;
  endfunction

  task automatic test_reset();
    step();
    step();
    n_tests += 6;
    if (fifo_pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %0h expected 0", fifo_pop); end
    if (in_fm_wena !== '0) begin n_fail++; $display("FAIL reset_wena: got %0h expected 0", in_fm_wena); end
    if (in_fm_waddr !== '0) begin n_fail++; $display("FAIL reset_waddr: got %0h expected 0", in_fm_waddr); end
    if (in_fm_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", in_fm_wdata); end
    if (store_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h expected 0", store_done); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    int c, base, e;
    bit to;
    clear_mon();
    load_words(TW, 1'b1);
    base = rd_ptr;
    start_tile(c);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL nom_busy_rise: got %0h expected 1", busy); end
    wait_done(1, 80, to);
    repeat (3) step();
    n_tests += 7;
    if (to) begin n_fail++; $display("FAIL nom_timeout: got no store_done expected one"); end
    if (first_done() != c + 35) begin n_fail++; $display("FAIL nom_done_cyc: got %0d expected %0d", first_done(), c + 35); end
    if (pop_cyc.size() != TW) begin n_fail++; $display("FAIL nom_pops: got %0d expected %0d", pop_cyc.size(), TW); end
    if (pop_cyc.size() > 0 && pop_cyc[0] != c + 1) begin n_fail++; $display("FAIL nom_first_pop: got %0d expected %0d", pop_cyc[0], c + 1); end
    if (wr_q.size() != TW) begin n_fail++; $display("FAIL nom_writes: got %0d expected %0d", wr_q.size(), TW); end
    e = write_errors(0, base, c, TW, 0, 1'b1);
    if (e != 0) begin n_fail++; $display("FAIL nom_write_data: got %0d bad writes expected 0", e); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL nom_busy_fall: got %0h expected 0", busy); end
  endtask

  task automatic test_empty_stall();
    int c, base, e, in_win;
    bit to;
    clear_mon();
    load_words(TW, 1'b0);
    base = rd_ptr;
    stall_lo = cyc + 5;
    stall_hi = cyc + 9;
    start_tile(c);
    wait_done(1, 80, to);
    repeat (3) step();
    stall_lo = -1;
    stall_hi = -1;
    in_win = 0;
    foreach (pop_cyc[i]) if (pop_cyc[i] >= c + 5 && pop_cyc[i] <= c + 9) in_win++;
    e = write_errors(0, base, c, 4, 5, 1'b1);
    n_tests += 5;
    if (to) begin n_fail++; $display("FAIL stall_timeout: got no store_done expected one"); end
    if (first_done() != c + 40) begin n_fail++; $display("FAIL stall_done_cyc: got %0d expected %0d", first_done(), c + 40); end
    if (in_win != 0) begin n_fail++; $display("FAIL stall_pops_in_window: got %0d expected 0", in_win); end
    if (pop_cyc.size() != TW) begin n_fail++; $display("FAIL stall_pops: got %0d expected %0d", pop_cyc.size(), TW); end
    if (e != 0) begin n_fail++; $display("FAIL stall_write_data: got %0d bad writes expected 0", e); end
  endtask

  task automatic test_random_stall();
    int c, base, e, last_w;
    bit to;
    clear_mon();
    load_words(TW, 1'b0);
    base = rd_ptr;
    rand_en = 1'b1;
    start_tile(c);
    wait_done(1, 600, to);
    rand_en = 1'b0;
    repeat (3) step();
    e = write_errors(0, base, c, TW, 0, 1'b0);
    last_w = (wr_q.size() > 0) ? wr_q[wr_q.size() - 1].c : -100;
    n_tests += 4;
    if (to) begin n_fail++; $display("FAIL rstall_timeout: got no store_done expected one"); end
    if (pop_cyc.size() != TW) begin n_fail++; $display("FAIL rstall_pops: got %0d expected %0d", pop_cyc.size(), TW); end
    if (e != 0) begin n_fail++; $display("FAIL rstall_write_data: got %0d bad writes expected 0", e); end
    if (first_done() != last_w + 1) begin n_fail++; $display("FAIL rstall_done_cyc: got %0d expected %0d", first_done(), last_w + 1); end
  endtask

  task automatic test_back_to_back();
    int c, c2, base, e1, e2, gap;
    bit to1, to2;
    clear_mon();
    load_words(2 * TW, 1'b0);
    base = rd_ptr;
    start_tile(c);
    wait_done(1, 80, to1);
    start_tile(c2);
    wait_done(2, 80, to2);
    repeat (3) step();
    gap = 0;
    foreach (pop_cyc[i]) if (pop_cyc[i] > c + TW && pop_cyc[i] <= c2) gap++;
    e1 = write_errors(0, base, c, TW, 0, 1'b1);
    e2 = write_errors(TW, base + TW, c2, TW, 0, 1'b1);
    n_tests += 6;
    if (to1 || to2) begin n_fail++; $display("FAIL b2b_timeout: got %0d dones expected 2", done_cyc.size()); end
    if (done_cyc.size() > 1 && done_cyc[1] != c2 + 35) begin n_fail++; $display("FAIL b2b_done2_cyc: got %0d expected %0d", done_cyc[1], c2 + 35); end
    if (gap != 0) begin n_fail++; $display("FAIL b2b_gap_pops: got %0d expected 0", gap); end
    if (pop_cyc.size() != 2 * TW) begin n_fail++; $display("FAIL b2b_pops: got %0d expected %0d", pop_cyc.size(), 2 * TW); end
    if (e1 != 0) begin n_fail++; $display("FAIL b2b_tile1_data: got %0d bad writes expected 0", e1); end
    if (e2 != 0) begin n_fail++; $display("FAIL b2b_tile2_data: got %0d bad writes expected 0", e2); end
  endtask

  task automatic test_start_busy();
    int c, base, e;
    clear_mon();
    load_words(TW, 1'b0);
    base = rd_ptr;
    start_tile(c);
    while (cyc < c + 45) begin
      store_start = (cyc == c + 10) || (cyc == c + 35);
      step();
    end
    store_start = 1'b0;
    e = write_errors(0, base, c, TW, 0, 1'b1);
    n_tests += 5;
    if (done_cyc.size() != 1) begin n_fail++; $display("FAIL busy_done_count: got %0d expected 1", done_cyc.size()); end
    if (first_done() != c + 35) begin n_fail++; $display("FAIL busy_done_cyc: got %0d expected %0d", first_done(), c + 35); end
    if (pop_cyc.size() != TW) begin n_fail++; $display("FAIL busy_pops: got %0d expected %0d", pop_cyc.size(), TW); end
    if (e != 0) begin n_fail++; $display("FAIL busy_write_data: got %0d bad writes expected 0", e); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle_after_done_start: got %0h expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int c, c2, base, e;
    bit to;
    clear_mon();
    load_words(TW, 1'b0);
    start_tile(c);
    while (cyc < c + 12) step();
    rst = 1'b0;
    #1;
    n_tests += 6;
    if (fifo_pop !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pop: got %0h expected 0", fifo_pop); end
    if (in_fm_wena !== '0) begin n_fail++; $display("FAIL mid_rst_wena: got %0h expected 0", in_fm_wena); end
    if (in_fm_waddr !== '0) begin n_fail++; $display("FAIL mid_rst_waddr: got %0h expected 0", in_fm_waddr); end
    if (in_fm_wdata !== '0) begin n_fail++; $display("FAIL mid_rst_wdata: got %0h expected 0", in_fm_wdata); end
    if (store_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %0h expected 0", store_done); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %0h expected 0", busy); end
    step();
    step();
    rst = 1'b1;
    step();
    clear_mon();
    load_words(TW, 1'b0);
    base = rd_ptr;
    start_tile(c2);
    wait_done(1, 80, to);
    repeat (3) step();
    e = write_errors(0, base, c2, TW, 0, 1'b1);
    n_tests += 4;
    if (to) begin n_fail++; $display("FAIL mid_new_timeout: got no store_done expected one"); end
    if (wr_q.size() == 0 || wr_q[0].wena !== TN'(1) || wr_q[0].addr !== '0) begin
      n_fail++;
      $display("FAIL mid_new_first_write: got wena %0h addr %0h expected wena 1 addr 0",
               (wr_q.size() > 0) ? wr_q[0].wena : '0, (wr_q.size() > 0) ? wr_q[0].addr : '0);
    end
    if (e != 0) begin n_fail++; $display("FAIL mid_new_write_data: got %0d bad writes expected 0", e); end
    if (first_done() != c2 + 35) begin n_fail++; $display("FAIL mid_new_done_cyc: got %0d expected %0d", first_done(), c2 + 35); end
  endtask

  task automatic test_default_params();
    int c;
    bit to;
    def_start = 1'b1;
    c = cyc;
    step();
    def_start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < DEF_TW + 100; i++) begin
      if (def_done_n > 0) begin
        to = 1'b0;
        break;
      end
      step();
    end
    repeat (3) step();
    n_tests += 6;
    if (to) begin n_fail++; $display("FAIL def_timeout: got no store_done expected one"); end
    if (def_done_cyc != c + DEF_TW + 3) begin n_fail++; $display("FAIL def_done_cyc: got %0d expected %0d", def_done_cyc, c + DEF_TW + 3); end
    if (def_wr_cnt != DEF_TW) begin n_fail++; $display("FAIL def_write_count: got %0d expected %0d", def_wr_cnt, DEF_TW); end
    if (def_bad != 0) begin n_fail++; $display("FAIL def_write_data: got %0d bad writes expected 0", def_bad); end
    if (def_last_wena !== (16'(1) << (DEF_TN - 1))) begin n_fail++; $display("FAIL def_last_bank: got %0h expected %0h", def_last_wena, 16'(1) << (DEF_TN - 1)); end
    if (def_last_addr !== AW'((DEF_TRI - 1) * DEF_TCI + DEF_TCI - 1)) begin n_fail++; $display("FAIL def_last_addr: got %0d expected %0d", def_last_addr, (DEF_TRI - 1) * DEF_TCI + DEF_TCI - 1); end
  endtask

  initial begin
    rst = 1'b0;
    store_start = 1'b0;
    def_start = 1'b0;
    test_reset();
    test_nominal();
    test_empty_stall();
    test_random_stall();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    test_default_params();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
